instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of the 16-bit PC register of the accumulator processor. On command from the control unit it reads the instruction at the current PC from instruction memory over a ready-based handshake and latches it into the instruction register. It then drives the PC register's next-value and write-enable inputs with PC+2, or with a branch/jump target on redirect. It also detects memory timeouts.

---
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch stage feeding the PC register
// Reads the word at PC over a ready handshake, latches IR and drives PC+2 or a redirect target.
module instruction_fetch_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] PC,
  input  logic        Start,
  input  logic        Redirect,
  input  logic [15:0] RedirectTarget,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [15:0] IR,
  output logic [15:0] PCIn,
  output logic        PCWrite,
  output logic        Done,
  output logic        RedirectAck,
  output logic        Busy,
  output logic        Fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_FAULT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [15:0] mem_addr_nxt, ir_nxt, pc_in_nxt;
  logic        mem_read_nxt, pc_write_nxt, done_nxt, redirect_ack_nxt, busy_nxt, fault_nxt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      MemAddr     <= 16'h0000;
      MemRead     <= 1'b0;
      IR          <= 16'h0000;
      PCIn        <= 16'h0000;
      PCWrite     <= 1'b0;
      Done        <= 1'b0;
      RedirectAck <= 1'b0;
      Busy        <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      MemAddr     <= mem_addr_nxt;
      MemRead     <= mem_read_nxt;
      IR          <= ir_nxt;
      PCIn        <= pc_in_nxt;
      PCWrite     <= pc_write_nxt;
      Done        <= done_nxt;
      RedirectAck <= redirect_ack_nxt;
      Busy        <= busy_nxt;
      Fault       <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!Redirect && Start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Redirect)                      state_nxt = S_IDLE;
        else if (MemReady)                 state_nxt = S_UPDATE;
        else if (wait_cnt == TIMEOUT_LAST) state_nxt = S_FAULT;
      end
      S_UPDATE: state_nxt = S_IDLE;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses default low, the rest hold.
  always_comb begin
    wait_cnt_nxt     = wait_cnt;
    mem_addr_nxt     = MemAddr;
    mem_read_nxt     = MemRead;
    ir_nxt           = IR;
    pc_in_nxt        = PCIn;
    pc_write_nxt     = 1'b0;
    done_nxt         = 1'b0;
    redirect_ack_nxt = 1'b0;
    fault_nxt        = Fault;
    case (state)
      S_IDLE: begin
        if (Redirect) begin
          pc_in_nxt        = RedirectTarget;
          pc_write_nxt     = 1'b1;
          redirect_ack_nxt = 1'b1;
        end else if (Start) begin
          mem_addr_nxt = PC;
          mem_read_nxt = 1'b1;
          wait_cnt_nxt = 8'd0;
        end
      end
      S_WAIT: begin
        if (Redirect) begin
          // Abort drops any word returned in this same cycle.
          mem_read_nxt     = 1'b0;
          pc_in_nxt        = RedirectTarget;
          pc_write_nxt     = 1'b1;
          redirect_ack_nxt = 1'b1;
        end else if (MemReady) begin
          ir_nxt       = MemData;
          pc_in_nxt    = MemAddr + 16'd2;
          mem_read_nxt = 1'b0;
          pc_write_nxt = 1'b1;
          done_nxt     = 1'b1;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          mem_read_nxt = 1'b0;
          fault_nxt    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_FAULT: mem_read_nxt = 1'b0;
      default: ;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
// Directed test-plan scenarios with literal checks, then randomized traffic against a fetch model.
module tb_instruction_fetch_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        Reset, Start, Redirect, MemReady;
  logic [15:0] PC, RedirectTarget, MemData;
  logic [15:0] MemAddr, IR, PCIn;
  logic        MemRead, PCWrite, Done, RedirectAck, Busy, Fault;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .Start(Start), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .MemData(MemData), .MemReady(MemReady),
    .MemAddr(MemAddr), .MemRead(MemRead), .IR(IR), .PCIn(PCIn),
    .PCWrite(PCWrite), .Done(Done), .RedirectAck(RedirectAck),
    .Busy(Busy), .Fault(Fault)
  );

  initial forever #5 CLK = ~CLK;

  // Model: a fetch is either in flight (with its age in WAIT cycles), retiring, or the unit is faulted.
  logic        model_valid = 1'b0;
  logic        in_flight = 1'b0, retiring = 1'b0, faulted = 1'b0;
  int          age = 0;
  int          fault_age = 0;
  logic [15:0] e_addr = '0, e_ir = '0, e_pcin = '0;
  logic        e_pcwrite = 0, e_done = 0, e_ack = 0;

  always @(posedge CLK) begin
    e_pcwrite = 0; e_done = 0; e_ack = 0;
    if (Reset) begin
      model_valid = 1'b1;
      in_flight = 0; retiring = 0; faulted = 0; age = 0; fault_age = 0;
      e_addr = 16'h0; e_ir = 16'h0; e_pcin = 16'h0;
    end else if (faulted) begin
      fault_age++;
    end else if (retiring) begin
      retiring = 0;
    end else if (in_flight) begin
      age++;
      if (Redirect) begin
        in_flight = 0; e_pcin = RedirectTarget; e_pcwrite = 1; e_ack = 1;
      end else if (MemReady) begin
        in_flight = 0; retiring = 1;
        e_ir = MemData; e_pcin = 16'((32'(e_addr) + 2) % 65536);
        e_pcwrite = 1; e_done = 1;
      end else if (age == TO) begin
        in_flight = 0; faulted = 1;
      end
    end else if (Redirect) begin
      e_pcin = RedirectTarget; e_pcwrite = 1; e_ack = 1;
    end else if (Start) begin
      in_flight = 1; age = 0; e_addr = PC;
    end
  end

  wire [53:0] act_vec = {MemAddr, MemRead, IR, PCIn, PCWrite, Done, RedirectAck, Busy, Fault};
  wire [53:0] exp_vec = {e_addr, in_flight, e_ir, e_pcin, e_pcwrite, e_done, e_ack,
                         (in_flight | retiring | faulted), faulted};

  always @(negedge CLK) begin
    if (model_valid) begin
      n_checks++;
      if (act_vec === exp_vec) n_pass++;
      else $display("FAIL model t=%0t got addr=%h rd=%b ir=%h pcin=%h wr=%b done=%b ack=%b busy=%b fault=%b want addr=%h rd=%b ir=%h pcin=%h wr=%b done=%b ack=%b busy=%b fault=%b",
                    $time, MemAddr, MemRead, IR, PCIn, PCWrite, Done, RedirectAck, Busy, Fault,
                    e_addr, in_flight, e_ir, e_pcin, e_pcwrite, e_done, e_ack,
                    (in_flight | retiring | faulted), faulted);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, act, exp);
  endtask

  task automatic idle_inputs();
    Reset = 0; Start = 0; Redirect = 0; MemReady = 0;
  endtask

  initial begin
    Reset = 1; Start = 0; Redirect = 0; MemReady = 0;
    PC = 16'h0; RedirectTarget = 16'h0; MemData = 16'h0;
    tick(); tick();
    chk("reset_outs", {MemRead, PCWrite, Done, RedirectAck, Busy, Fault}, 16'h0);
    chk("reset_ir", IR, 16'h0);
    chk("reset_addr", MemAddr, 16'h0);
    Reset = 0;

    // Basic fetch
    PC = 16'h0010; Start = 1; tick();
    chk("basic_addr_c1", MemAddr, 16'h0010); chk("basic_rd_c1", MemRead, 1);
    Start = 0; tick();
    chk("basic_addr_c2", MemAddr, 16'h0010); chk("basic_wr_c2", PCWrite, 0);
    MemReady = 1; MemData = 16'hA5C3; tick();
    chk("basic_ir", IR, 16'hA5C3); chk("basic_pcin", PCIn, 16'h0012);
    chk("basic_pulses_c3", {PCWrite, Done, MemRead}, 16'h6);
    MemReady = 0; tick();
    chk("basic_pulses_c4", {PCWrite, Done, Busy}, 16'h0);

    // Wrap
    PC = 16'hFFFE; Start = 1; tick();
    Start = 0; MemReady = 1; MemData = 16'h1357; tick();
    chk("wrap_pcin", PCIn, 16'h0000); chk("wrap_wr", PCWrite, 1);
    MemReady = 0; tick();

    // Redirect abort with same-cycle MemReady
    PC = 16'h0100; Start = 1; tick();
    Start = 0; Redirect = 1; RedirectTarget = 16'h0400; MemReady = 1; MemData = 16'hBEEF; tick();
    chk("abort_ir", IR, 16'h1357); chk("abort_pcin", PCIn, 16'h0400);
    chk("abort_pulses", {PCWrite, RedirectAck, Done, MemRead, Busy}, 16'h18);
    Redirect = 0; MemReady = 0; tick();
    chk("abort_after", {PCWrite, RedirectAck, Busy}, 16'h0);

    // Collision in IDLE
    Start = 1; Redirect = 1; RedirectTarget = 16'h1234; tick();
    chk("coll_rd", MemRead, 0); chk("coll_pcin", PCIn, 16'h1234); chk("coll_wr", PCWrite, 1);
    Redirect = 0; PC = 16'h0222; tick();
    chk("coll_addr", MemAddr, 16'h0222); chk("coll_rd2", MemRead, 1);
    Start = 0; MemReady = 1; tick();
    MemReady = 0; tick();

    // Timeout with MEM_TIMEOUT=4
    PC = 16'h0300; Start = 1; tick();
    Start = 0;
    for (int c = 1; c <= TO; c++) begin
      chk("to_wait_rd", MemRead, 1); chk("to_wait_fault", Fault, 0);
      tick();
    end
    chk("to_fault", {Fault, MemRead, Busy}, 16'h5);
    Start = 1; Redirect = 1; RedirectTarget = 16'h0777; tick();
    chk("to_ignore_wr", PCWrite, 0); chk("to_sticky", Fault, 1);
    Start = 0; Redirect = 0; Reset = 1; tick();
    chk("to_reset", {Fault, Busy}, 16'h0);
    Reset = 0; tick();

    // Reset mid-WAIT
    PC = 16'h0500; Start = 1; tick();
    Start = 0; tick();
    Reset = 1; tick();
    chk("rst_wait_outs", {MemRead, PCWrite, Done, RedirectAck, Busy, Fault}, 16'h0);
    chk("rst_wait_ir", IR, 16'h0); chk("rst_wait_addr", MemAddr, 16'h0);
    Reset = 0; MemReady = 1; MemData = 16'h1111; tick();
    chk("rst_late_ready", IR, 16'h0); chk("rst_late_done", Done, 0);
    idle_inputs(); tick();

    // Randomized traffic; the controller side honours the redirect hold/drop protocol.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      Reset = ($urandom_range(0, 149) == 0) || (faulted && fault_age > 3);
      if (Redirect && e_ack) Redirect = 0;
      else if (!Redirect && $urandom_range(0, 9) == 0) begin
        Redirect = 1;
        RedirectTarget = 16'($urandom);
      end
      Start    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       PC = 16'hFFFE;
        1:       PC = 16'hFFFF;
        default: PC = 16'($urandom);
      endcase
      MemReady = ($urandom_range(0, 99) < 45);
      MemData  = 16'($urandom);
      tick();
    end

    idle_inputs(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
